// File: rtl/aes_ctrl_pkg.sv
// rtl/aes_ctrl_pkg.sv - shared types and widths for AES job controllers
package aes_ctrl_pkg;

  localparam int AES_BLK_W  = 128;
  localparam int AES_KSEL_W = 2;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP,
    DRAIN
  } aes_sched_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick of the first request after ptr
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);

  logic [IW-1:0] cand;

  // Walk ptr+1 .. ptr+N so the last winner has the lowest priority.
  always_comb begin
    gnt  = '0;
    idx  = '0;
    any  = 1'b0;
    cand = '0;
    for (int k = 1; k <= N; k++) begin
      cand = IW'((int'(ptr) + k) % N);
      if (!any && req[cand]) begin
        any = 1'b1;
        idx = cand;
      end
    end
    if (any) gnt[idx] = 1'b1;
  end

endmodule

// File: rtl/aes2_job_scheduler.sv
// rtl/aes2_job_scheduler.sv - shares one AES-192 core among N_REQ requesters, one job at a time
module aes2_job_scheduler
  import aes_ctrl_pkg::*;
#(
  parameter int N_REQ          = 4,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [N_REQ-1:0]          req_en_i,
  input  logic [N_REQ-1:0]          req_valid_i,
  output logic [N_REQ-1:0]          req_ready_o,
  input  logic [N_REQ*AES_BLK_W-1:0]  req_pt_i,
  input  logic [N_REQ*AES_KSEL_W-1:0] req_key_sel_i,
  output logic [N_REQ-1:0]          rsp_valid_o,
  input  logic [N_REQ-1:0]          rsp_ready_i,
  output logic [AES_BLK_W-1:0]      rsp_ct_o,
  output logic                      rsp_err_o,
  output logic                      core_start_o,
  output logic [AES_BLK_W-1:0]      core_pt_o,
  output logic [AES_KSEL_W-1:0]     core_key_sel_o,
  input  logic [AES_BLK_W-1:0]      core_ct_i,
  input  logic                      core_ct_valid_i,
  output logic                      busy_o,
  output logic [31:0]               job_count_o
);

  localparam int IW = $clog2(N_REQ);
  localparam int TW = $clog2(TIMEOUT_CYCLES);

  aes_sched_state_e state;
  logic [IW-1:0]    ptr;
  logic [IW-1:0]    g_idx;
  logic [TW-1:0]    timer;

  logic [N_REQ-1:0] arb_gnt;
  logic [IW-1:0]    arb_idx;
  logic             arb_any;

  logic [AES_BLK_W-1:0]  pt_arr [N_REQ];
  logic [AES_KSEL_W-1:0] ks_arr [N_REQ];

  for (genvar i = 0; i < N_REQ; i++) begin : g_slice
    assign pt_arr[i] = req_pt_i[i*AES_BLK_W +: AES_BLK_W];
    assign ks_arr[i] = req_key_sel_i[i*AES_KSEL_W +: AES_KSEL_W];
  end

  rr_arbiter #(.N(N_REQ), .IW(IW)) u_arb (
    .req (req_valid_i & req_en_i),
    .ptr (ptr),
    .gnt (arb_gnt),
    .idx (arb_idx),
    .any (arb_any)
  );

  // Accept is a same-cycle handshake, so it cannot be registered.
  assign req_ready_o = (state == IDLE && !rst_i) ? arb_gnt : '0;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state          <= IDLE;
      ptr            <= IW'(N_REQ - 1);
      g_idx          <= '0;
      timer          <= '0;
      rsp_valid_o    <= '0;
      rsp_ct_o       <= '0;
      rsp_err_o      <= 1'b0;
      core_start_o   <= 1'b0;
      core_pt_o      <= '0;
      core_key_sel_o <= '0;
      busy_o         <= 1'b0;
      job_count_o    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (arb_any) begin
            g_idx          <= arb_idx;
            ptr            <= arb_idx;
            core_pt_o      <= pt_arr[arb_idx];
            core_key_sel_o <= ks_arr[arb_idx];
            core_start_o   <= 1'b1;
            busy_o         <= 1'b1;
            state          <= ISSUE;
          end
        end
        ISSUE: begin
          timer <= '0;
          state <= WAIT;
        end
        WAIT: begin
          timer <= timer + 1'b1;
          // A result arriving on the last timeout cycle still wins.
          if (core_ct_valid_i) begin
            rsp_ct_o     <= core_ct_i;
            rsp_err_o    <= 1'b0;
            rsp_valid_o  <= N_REQ'(1) << g_idx;
            core_start_o <= 1'b0;
            state        <= RESP;
          end else if (timer == TW'(TIMEOUT_CYCLES - 1)) begin
            rsp_ct_o     <= '0;
            rsp_err_o    <= 1'b1;
            rsp_valid_o  <= N_REQ'(1) << g_idx;
            core_start_o <= 1'b0;
            state        <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready_i[g_idx]) begin
            rsp_valid_o <= '0;
            rsp_ct_o    <= '0;
            rsp_err_o   <= 1'b0;
            job_count_o <= job_count_o + 32'd1;
            state       <= DRAIN;
          end
        end
        DRAIN: begin
          // Hold off the next grant until the core's stale out_valid clears.
          if (!core_ct_valid_i) begin
            busy_o <= 1'b0;
            state  <= IDLE;
          end
        end
        default: begin
          core_start_o <= 1'b0;
          rsp_valid_o  <= '0;
          busy_o       <= 1'b0;
          state        <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aes2_job_scheduler.sv
// tb/tb_aes2_job_scheduler.sv - scoreboard bench for aes2_job_scheduler with a behavioural core
module tb_aes2_job_scheduler;

  localparam int N   = 4;
  localparam int TMO = 32;

  logic             clk_i = 1'b0;
  logic             rst_i;
  logic [N-1:0]     req_en_i;
  logic [N-1:0]     req_valid_i;
  logic [N-1:0]     req_ready_o;
  logic [N*128-1:0] req_pt_i;
  logic [N*2-1:0]   req_key_sel_i;
  logic [N-1:0]     rsp_valid_o;
  logic [N-1:0]     rsp_ready_i;
  logic [127:0]     rsp_ct_o;
  logic             rsp_err_o;
  logic             core_start_o;
  logic [127:0]     core_pt_o;
  logic [1:0]       core_key_sel_o;
  logic [127:0]     core_ct_i;
  logic             core_ct_valid_i;
  logic             busy_o;
  logic [31:0]      job_count_o;

  always #5 clk_i = ~clk_i;

  aes2_job_scheduler #(.N_REQ(N), .TIMEOUT_CYCLES(TMO)) dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .req_en_i        (req_en_i),
    .req_valid_i     (req_valid_i),
    .req_ready_o     (req_ready_o),
    .req_pt_i        (req_pt_i),
    .req_key_sel_i   (req_key_sel_i),
    .rsp_valid_o     (rsp_valid_o),
    .rsp_ready_i     (rsp_ready_i),
    .rsp_ct_o        (rsp_ct_o),
    .rsp_err_o       (rsp_err_o),
    .core_start_o    (core_start_o),
    .core_pt_o       (core_pt_o),
    .core_key_sel_o  (core_key_sel_o),
    .core_ct_i       (core_ct_i),
    .core_ct_valid_i (core_ct_valid_i),
    .busy_o          (busy_o),
    .job_count_o     (job_count_o)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] model_ct(input logic [127:0] pt, input logic [1:0] ks);
    return {pt[95:0], pt[127:96]} ^ {126'd0, ks} ^ 128'h5a5a_0f0f_c3c3_3c3c_a5a5_f0f0_1234_8765;
  endfunction

  function automatic int ix(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return -1;
  endfunction

  // Requester data tables
  logic [127:0] pt_tab [N];
  logic [1:0]   ks_tab [N];

  always_comb begin
    req_pt_i      = '0;
    req_key_sel_i = '0;
    for (int i = 0; i < N; i++) begin
      req_pt_i[128*i +: 128]  = pt_tab[i];
      req_key_sel_i[2*i +: 2] = ks_tab[i];
    end
  end

  // Behavioural core: valid after lat cycles of start, optionally held after start drops
  int lat;
  int hold;
  bit never;
  int cnt;
  int hold_cnt;

  always @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt      <= 0;
      hold_cnt <= 0;
    end else if (core_start_o) begin
      cnt <= cnt + 1;
      if (core_ct_valid_i) hold_cnt <= hold;
    end else begin
      cnt <= 0;
      if (hold_cnt > 0) hold_cnt <= hold_cnt - 1;
    end
  end

  assign core_ct_valid_i = core_start_o ? (!never && cnt >= lat) : (hold_cnt > 0);
  assign core_ct_i       = model_ct(core_pt_o, core_key_sel_o);

  // Scoreboard and monitor
  typedef struct {
    int           idx;
    logic [127:0] ct;
    logic         err;
  } exp_t;

  exp_t sb [$];
  int   gnt_log [$];
  int   rsp_seen = 0;
  int   run_ctr  = 0;
  int   last_run = 0;
  exp_t mon_e;
  int   mon_i;

  always @(negedge clk_i) begin
    if (!rst_i) begin
      if (req_ready_o != '0) begin
        check("rdy_onehot", 128'($onehot(req_ready_o)), 128'd1);
        check("rdy_with_rsp", 128'(rsp_valid_o), 128'd0);
        check("grant_while_core_valid", 128'(core_ct_valid_i), 128'd0);
        mon_i = ix(req_ready_o);
        gnt_log.push_back(mon_i);
        mon_e.idx = mon_i;
        mon_e.err = never || (lat > TMO);
        mon_e.ct  = mon_e.err ? 128'd0 : model_ct(pt_tab[mon_i], ks_tab[mon_i]);
        sb.push_back(mon_e);
      end
      if ((rsp_valid_o & rsp_ready_i) != '0) begin
        if (sb.size() == 0) begin
          check("rsp_unexpected", 128'(rsp_valid_o), 128'd0);
        end else begin
          mon_e = sb.pop_front();
          check("rsp_idx", 128'(ix(rsp_valid_o)), 128'(mon_e.idx));
          check("rsp_onehot", 128'($onehot(rsp_valid_o)), 128'd1);
          check("rsp_ct", rsp_ct_o, mon_e.ct);
          check("rsp_err", 128'(rsp_err_o), 128'(mon_e.err));
        end
        rsp_seen++;
      end
      if (core_start_o) begin
        run_ctr++;
      end else if (run_ctr != 0) begin
        last_run = run_ctr;
        run_ctr  = 0;
      end
    end
  end

  task automatic do_reset();
    rst_i = 1'b1;
    sb.delete();
    repeat (2) @(posedge clk_i);
    #1 rst_i = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy_o && n < 2000) begin
      @(posedge clk_i);
      #1 n++;
    end
    check("idle_timeout", 128'(busy_o), 128'd0);
  endtask

  task automatic run_jobs(input logic [N-1:0] v, input int njobs);
    int bg = gnt_log.size();
    int br = rsp_seen;
    int n  = 0;
    req_valid_i = v;
    while ((gnt_log.size() - bg) < njobs && n < 5000) begin
      @(posedge clk_i);
      #1 n++;
    end
    req_valid_i = '0;
    check("grant_timeout", 128'((gnt_log.size() - bg) >= njobs), 128'd1);
    n = 0;
    while ((rsp_seen - br) < njobs && n < 5000) begin
      @(posedge clk_i);
      #1 n++;
    end
    check("rsp_timeout", 128'((rsp_seen - br) >= njobs), 128'd1);
    wait_idle();
  endtask

  int bg;
  int n;
  int exp_order [8];
  logic [127:0] exp_ct;

  initial begin
    rst_i       = 1'b1;
    req_valid_i = '0;
    req_en_i    = '1;
    rsp_ready_i = '1;
    lat         = 20;
    hold        = 0;
    never       = 1'b0;
    for (int i = 0; i < N; i++) begin
      pt_tab[i] = {$urandom, $urandom, $urandom, $urandom};
      ks_tab[i] = 2'(i);
    end
    do_reset();

    @(negedge clk_i);
    check("rst_busy", 128'(busy_o), 128'd0);
    check("rst_count", 128'(job_count_o), 128'd0);
    check("rst_start", 128'(core_start_o), 128'd0);
    check("rst_rsp_valid", 128'(rsp_valid_o), 128'd0);
    check("rst_core_pt", core_pt_o, 128'd0);
    check("rst_rsp_ct", rsp_ct_o, 128'd0);
    @(posedge clk_i);
    #1;

    // Single job from requester 0
    pt_tab[0] = 128'h00112233_44556677_8899aabb_ccddeeff;
    ks_tab[0] = 2'd0;
    bg = gnt_log.size();
    run_jobs(4'b0001, 1);
    check("single_grants", 128'(gnt_log.size() - bg), 128'd1);
    check("single_gnt_idx", 128'(gnt_log[bg]), 128'd0);
    check("single_start_cycles", 128'(last_run), 128'd21);
    check("single_count", 128'(job_count_o), 128'd1);

    // Fairness, all enabled
    ks_tab[0] = 2'd0;
    do_reset();
    lat = 3;
    exp_order = '{0, 1, 2, 3, 0, 1, 2, 3};
    bg = gnt_log.size();
    run_jobs(4'b1111, 8);
    for (int k = 0; k < 8; k++) check($sformatf("rr_all_%0d", k), 128'(gnt_log[bg+k]), 128'(exp_order[k]));
    check("rr_all_count", 128'(job_count_o), 128'd8);

    // Fairness with requester 2 disabled
    do_reset();
    req_en_i  = 4'b1011;
    exp_order = '{0, 1, 3, 0, 0, 0, 0, 0};
    bg = gnt_log.size();
    run_jobs(4'b1111, 4);
    for (int k = 0; k < 4; k++) check($sformatf("rr_en_%0d", k), 128'(gnt_log[bg+k]), 128'(exp_order[k]));
    check("rr_en_count", 128'(job_count_o), 128'd4);
    req_en_i = '1;

    // Timeout: core never answers
    do_reset();
    never = 1'b1;
    run_jobs(4'b0010, 1);
    check("tmo_start_cycles", 128'(last_run), 128'(TMO + 1));
    check("tmo_count", 128'(job_count_o), 128'd1);

    // Result lands on the final timeout cycle
    never = 1'b0;
    lat   = TMO;
    run_jobs(4'b0100, 1);
    check("tie_start_cycles", 128'(last_run), 128'(TMO + 1));
    check("tie_count", 128'(job_count_o), 128'd2);

    // Backpressure and drain with a lingering core valid
    lat         = 5;
    hold        = 15;
    rsp_ready_i = '0;
    bg          = gnt_log.size();
    req_valid_i = 4'b0011;
    n = 0;
    while (gnt_log.size() == bg && n < 500) begin
      @(posedge clk_i);
      #1 n++;
    end
    req_valid_i = 4'b0010;
    n = 0;
    while (rsp_valid_o == '0 && n < 500) begin
      @(posedge clk_i);
      #1 n++;
    end
    check("bp_rsp_seen", 128'(rsp_valid_o), 128'b0001);
    exp_ct = model_ct(pt_tab[0], ks_tab[0]);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk_i);
      check($sformatf("bp_valid_%0d", k), 128'(rsp_valid_o), 128'b0001);
      check($sformatf("bp_ct_%0d", k), rsp_ct_o, exp_ct);
      check($sformatf("bp_no_grant_%0d", k), 128'(req_ready_o), 128'd0);
    end
    @(posedge clk_i);
    #1 rsp_ready_i = '1;
    n = 0;
    while (gnt_log.size() < bg + 2 && n < 500) begin
      @(posedge clk_i);
      #1 n++;
    end
    req_valid_i = '0;
    check("bp_grant_count", 128'(gnt_log.size() - bg), 128'd2);
    check("bp_first_gnt", 128'(gnt_log[bg]), 128'd0);
    check("bp_second_gnt", 128'(gnt_log[bg+1]), 128'd1);
    n = 0;
    while (busy_o && n < 500) begin
      @(posedge clk_i);
      #1 n++;
    end
    wait_idle();
    check("bp_count", 128'(job_count_o), 128'd4);
    hold = 0;

    // Reset in the middle of WAIT
    never       = 1'b1;
    bg          = gnt_log.size();
    req_valid_i = 4'b0100;
    n = 0;
    while (gnt_log.size() == bg && n < 500) begin
      @(posedge clk_i);
      #1 n++;
    end
    req_valid_i = '0;
    repeat (5) @(posedge clk_i);
    #2 rst_i = 1'b1;
    #1;
    check("mid_rst_start", 128'(core_start_o), 128'd0);
    check("mid_rst_busy", 128'(busy_o), 128'd0);
    check("mid_rst_count", 128'(job_count_o), 128'd0);
    check("mid_rst_rsp", 128'(rsp_valid_o), 128'd0);
    sb.delete();
    @(posedge clk_i);
    #1 rst_i = 1'b0;
    never = 1'b0;
    lat   = 3;
    bg    = gnt_log.size();
    run_jobs(4'b0101, 1);
    check("post_rst_gnt", 128'(gnt_log[bg]), 128'd0);
    check("post_rst_count", 128'(job_count_o), 128'd1);
    check("sb_drained", 128'(sb.size()), 128'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
